rnd_key_bank: RTL and testbench
===============================

# rnd_key_bank

Double-buffered, parametrised round-key store for the DES/LFSR-Feistel datapath. The key schedule streams a full round-key set into a shadow bank while the Feistel engine reads the active bank. The two banks swap automatically when the shadow set is complete and the reader is idle. Reads are streamed one key per beat, either forward for encryption or reverse for decryption, under valid/ready flow control.

## Interface
- KEY_WIDTH, 48, width of one round key
- DEPTH, 16, round keys per set; must be ≥ 2
- ADDR_WIDTH, 4, index width; must be ≥ clog2(DEPTH)
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  synchronous, active-low reset
- wr_valid  in  1  write beat offered
- wr_data  in  KEY_WIDTH  round key for the current write index
- wr_ready  out  1  shadow bank accepts a beat
- load_clear  in  1  discard the partial shadow fill and restart it at index 0
- rd_start  in  1  request one full stream of the active set
- rd_dir  in  1  sampled with rd_start: 0 streams 0→DEPTH-1 (encrypt); 1 streams DEPTH-1→0 (decrypt)
- rd_valid  out  1  rd_data/rd_idx/rd_last are valid
- rd_ready  in  1  consumer accepts the current beat
- rd_data  out  KEY_WIDTH  round key
- rd_idx  out  ADDR_WIDTH  memory index of rd_data
- rd_last  out  1  final beat of the stream
- keys_ready  out  1  active bank holds a complete set
- busy  out  1  reader in STREAM
- swap  out  1  one-cycle pulse when the banks swap

## Operation
- Storage: 2×DEPTH×KEY_WIDTH. The active-bank select bit `act` is reset to 0. Memory contents are not reset.
- Writer: wr_ptr, shadow_full.
  - wr_ready = !shadow_full.
  - Each beat with wr_valid & wr_ready writes mem[!act][wr_ptr] and increments wr_ptr.
  - On the beat at wr_ptr = DEPTH-1, shadow_full is set and wr_ptr wraps to 0.
  - load_clear sets wr_ptr to 0 and clears shadow_full. It wins over a same-cycle write beat, which is dropped.
- Reader FSM, IDLE/STREAM:
  - IDLE→STREAM on rd_start & keys_ready & !swap_cond. The FSM latches rd_dir and loads the start index (0 or DEPTH-1).
  - rd_start is ignored when keys_ready = 0 or when the FSM is already in STREAM.
  - In STREAM, rd_valid = 1. The beat advances on rd_valid & rd_ready, stepping the index by +1 (dir 0) or −1 (dir 1).
  - rd_last = 1 at index DEPTH-1 (dir 0) or index 0 (dir 1).
  - The accepted last beat returns the FSM to IDLE.
- Swap:
  - swap_cond = shadow_full & state == IDLE & !(rd_start & keys_ready).
  - On swap_cond: act toggles, keys_ready is set, shadow_full clears, wr_ptr = 0, and swap pulses.
  - A pending rd_start wins. The swap is deferred until the FSM returns to IDLE.
- Reset (rst_n = 0 at an edge):
  - act = 0, FSM = IDLE, wr_ptr = 0, shadow_full = 0, keys_ready = 0.
  - rd_valid = 0, rd_last = 0, rd_data = 0, rd_idx = 0, busy = 0, swap = 0, wr_ready = 1 after the edge.
  - Reset during a stream or a fill aborts it. No further beats are produced.

## Timing
- rd_data, rd_idx and rd_last are registered.
- The first beat (rd_valid = 1) appears one cycle after the rd_start edge.
- With rd_ready held at 1, one key per cycle: DEPTH beats in DEPTH cycles, and IDLE on the cycle after the last beat.
- rd_ready = 0 holds rd_data, rd_idx and rd_last stable while rd_valid stays 1.
- A back-to-back rd_start is accepted on the first IDLE cycle, so there is a one-cycle gap between streams.
- The write completing a set is followed by the swap at the earliest one cycle later, if the reader is idle.
- wr_ready is 0 from the cycle after the DEPTH-th write until the cycle after the swap.
- keys_ready rises in the cycle after the first swap and stays at 1 until reset.

## Test plan
- Basic load and encrypt stream:
  - Stimulus: reset, then write keys 48'h000000000001..48'h000000000010 on 16 consecutive cycles.
  - Required: swap pulses once, keys_ready = 1.
  - Stimulus: rd_start with rd_dir = 0 and rd_ready = 1.
  - Required: 16 beats with rd_idx 0..15 and rd_data 1..16; rd_last only on idx 15.
- Decrypt stream with backpressure:
  - Stimulus: same set, rd_dir = 1, rd_ready toggled 1,0,1,0.
  - Required: rd_idx 15..0, rd_data 16..1; data held stable during rd_ready = 0; rd_last on idx 0; busy drops after it.
- Double-buffer overlap:
  - Stimulus: during an active stream, load a second set 48'hA00..48'hA0F.
  - Required: wr_ready goes to 0 after the 16th write. The current stream still returns the old keys. swap pulses on the first IDLE cycle, and the next stream returns 48'hA00...
- Simultaneous events:
  - Stimulus: rd_start in the same cycle the shadow bank becomes swap-eligible.
  - Required: the stream uses the old bank; swap occurs after its last beat.
  - Stimulus: load_clear together with wr_valid at wr_ptr = 7.
  - Required: the beat is dropped and wr_ptr = 0.
- Illegal requests:
  - Stimulus: rd_start before any full load.
  - Required: ignored; rd_valid stays 0.
  - Stimulus: rd_start mid-stream.
  - Required: ignored; the stream continues unchanged.
- Reset mid-operation:
  - Stimulus: rst_n = 0 at beat 5 of a stream and at wr_ptr = 9 of a fill.
  - Required: after the edge, rd_valid = 0, keys_ready = 0, wr_ready = 1, wr_ptr = 0. A fresh 16-key load followed by a stream works normally.

Source files
------------

// File: rtl/rnd_key_bank.sv
// Double-buffered round-key store: the key schedule fills the shadow bank while
// the Feistel engine streams the active bank forward (encrypt) or reverse (decrypt).
module rnd_key_bank #(
  parameter int KEY_WIDTH  = 48,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_valid,
  input  logic [KEY_WIDTH-1:0]  i_wr_data,
  output logic                  o_wr_ready,
  input  logic                  i_load_clear,
  input  logic                  i_rd_start,
  input  logic                  i_rd_dir,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [KEY_WIDTH-1:0]  o_rd_data,
  output logic [ADDR_WIDTH-1:0] o_rd_idx,
  output logic                  o_rd_last,
  output logic                  o_keys_ready,
  output logic                  o_busy,
  output logic                  o_swap,
  output logic                  o_dbg_state,
  output logic [ADDR_WIDTH-1:0] o_dbg_wr_ptr
);

  // Handshakes: a write beat transfers on an edge where i_wr_valid & o_wr_ready;
  // a read beat transfers on an edge where o_rd_valid & i_rd_ready, and the
  // presented beat is held stable until it transfers.

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  logic [KEY_WIDTH-1:0]  r_mem [0:1][0:DEPTH-1];
  logic                  r_act;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic                  r_shadow_full;
  logic                  r_keys_ready;
  logic                  r_swap;
  rd_state_t             r_state;
  logic                  r_dir;
  logic [ADDR_WIDTH-1:0] r_rd_idx;
  logic [KEY_WIDTH-1:0]  r_rd_data;
  logic                  r_rd_last;

  logic                  w_wr_fire;
  logic                  w_rd_accept;
  logic                  w_swap_cond;
  logic [ADDR_WIDTH-1:0] w_start_idx;
  logic [ADDR_WIDTH-1:0] w_next_idx;
  logic [ADDR_WIDTH-1:0] w_end_idx;

  // load_clear takes priority: a write beat offered alongside it is dropped.
  assign w_wr_fire   = i_wr_valid & ~r_shadow_full & ~i_load_clear;
  assign w_rd_accept = (r_state == ST_IDLE) & i_rd_start & r_keys_ready;
  // A read request that can be served beats a pending swap; the swap waits.
  assign w_swap_cond = r_shadow_full & (r_state == ST_IDLE) & ~(i_rd_start & r_keys_ready);

  assign w_start_idx = i_rd_dir ? LAST_IDX : '0;
  assign w_next_idx  = r_dir ? (r_rd_idx - 1'b1) : (r_rd_idx + 1'b1);
  assign w_end_idx   = r_dir ? '0 : LAST_IDX;

  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_wr_fire) begin
      r_mem[~r_act][r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_act         <= 1'b0;
      r_wr_ptr      <= '0;
      r_shadow_full <= 1'b0;
      r_keys_ready  <= 1'b0;
      r_swap        <= 1'b0;
    end else begin
      if (i_load_clear || w_swap_cond) begin
        r_wr_ptr      <= '0;
        r_shadow_full <= 1'b0;
      end else if (w_wr_fire) begin
        if (r_wr_ptr == LAST_IDX) begin
          r_wr_ptr      <= '0;
          r_shadow_full <= 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
      end
      if (w_swap_cond) begin
        r_act        <= ~r_act;
        r_keys_ready <= 1'b1;
      end
      r_swap <= w_swap_cond;
    end
  end

  // The active bank cannot change while streaming, since swaps only happen in IDLE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_dir     <= 1'b0;
      r_rd_idx  <= '0;
      r_rd_data <= '0;
      r_rd_last <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rd_accept) begin
            r_state   <= ST_STREAM;
            r_dir     <= i_rd_dir;
            r_rd_idx  <= w_start_idx;
            r_rd_data <= r_mem[r_act][w_start_idx];
            r_rd_last <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (i_rd_ready) begin
            if (r_rd_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_rd_idx  <= w_next_idx;
              r_rd_data <= r_mem[r_act][w_next_idx];
              r_rd_last <= (w_next_idx == w_end_idx);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_wr_ready   = ~r_shadow_full;
  assign o_rd_valid   = (r_state == ST_STREAM);
  assign o_rd_data    = r_rd_data;
  assign o_rd_idx     = r_rd_idx;
  assign o_rd_last    = r_rd_last;
  assign o_keys_ready = r_keys_ready;
  assign o_busy       = (r_state == ST_STREAM);
  assign o_swap       = r_swap;
  assign o_dbg_state  = r_state;
  assign o_dbg_wr_ptr = r_wr_ptr;

endmodule

// File: tb/tb_rnd_key_bank.sv
// Bench for rnd_key_bank: queue-based reference model, expected read beats in a
// scoreboard queue, and a negedge monitor comparing every cycle.
module tb_rnd_key_bank;

  localparam int KW    = 48;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int EW    = 1 + AW + KW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic [KW-1:0] wr_data;
  logic          load_clear;
  logic          rd_start;
  logic          rd_dir;
  logic          rd_ready;

  logic          dut_wr_ready;
  logic          dut_rd_valid;
  logic [KW-1:0] dut_rd_data;
  logic [AW-1:0] dut_rd_idx;
  logic          dut_rd_last;
  logic          dut_keys_ready;
  logic          dut_busy;
  logic          dut_swap;
  logic          dut_state;
  logic [AW-1:0] dut_wr_ptr;

  int checks   = 0;
  int failures = 0;

  rnd_key_bank #(.KEY_WIDTH(KW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_wr_valid   (wr_valid),
    .i_wr_data    (wr_data),
    .o_wr_ready   (dut_wr_ready),
    .i_load_clear (load_clear),
    .i_rd_start   (rd_start),
    .i_rd_dir     (rd_dir),
    .o_rd_valid   (dut_rd_valid),
    .i_rd_ready   (rd_ready),
    .o_rd_data    (dut_rd_data),
    .o_rd_idx     (dut_rd_idx),
    .o_rd_last    (dut_rd_last),
    .o_keys_ready (dut_keys_ready),
    .o_busy       (dut_busy),
    .o_swap       (dut_swap),
    .o_dbg_state  (dut_state),
    .o_dbg_wr_ptr (dut_wr_ptr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [KW-1:0] m_shadow[$];
  logic [KW-1:0] m_active [DEPTH];
  logic [EW-1:0] exp_q[$];
  logic          m_keys_ready = 1'b0;
  logic          m_stream     = 1'b0;
  int            m_left       = 0;
  logic          m_swap_pulse = 1'b0;
  logic          m_after_rst  = 1'b0;
  logic          m_started    = 1'b0;
  logic          m_start, m_do_swap, m_take;

  always @(posedge clk) begin : model
    if (!rst_n) begin
      m_shadow.delete();
      exp_q.delete();
      m_keys_ready = 1'b0;
      m_stream     = 1'b0;
      m_left       = 0;
      m_swap_pulse = 1'b0;
      m_after_rst  = 1'b1;
      m_started    = 1'b1;
    end else begin
      m_after_rst = 1'b0;
      m_start   = !m_stream && rd_start && m_keys_ready;
      m_do_swap = (m_shadow.size() == DEPTH) && !m_stream && !(rd_start && m_keys_ready);
      m_take    = wr_valid && !load_clear && (m_shadow.size() < DEPTH);
      if (m_stream && rd_ready) begin
        m_left--;
        if (m_left == 0) m_stream = 1'b0;
      end
      if (m_start) begin
        m_stream = 1'b1;
        m_left   = DEPTH;
        for (int k = 0; k < DEPTH; k++) begin
          int idx;
          idx = rd_dir ? (DEPTH - 1 - k) : k;
          exp_q.push_back({(k == DEPTH - 1) ? 1'b1 : 1'b0, AW'(idx), m_active[idx]});
        end
      end
      if (m_do_swap) begin
        for (int i = 0; i < DEPTH; i++) m_active[i] = m_shadow[i];
        m_shadow.delete();
        m_keys_ready = 1'b1;
      end
      m_swap_pulse = m_do_swap;
      if (load_clear) m_shadow.delete();
      else if (m_take) m_shadow.push_back(wr_data);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [EW-1:0] cur;

  always @(negedge clk) begin
    if (m_started) begin
      check("wr_ready",   64'(dut_wr_ready),   64'(m_shadow.size() != DEPTH));
      check("wr_ptr",     64'(dut_wr_ptr),     64'((m_shadow.size() == DEPTH) ? 0 : m_shadow.size()));
      check("keys_ready", 64'(dut_keys_ready), 64'(m_keys_ready));
      check("rd_valid",   64'(dut_rd_valid),   64'(m_stream));
      check("busy",       64'(dut_busy),       64'(m_stream));
      check("dbg_state",  64'(dut_state),      64'(m_stream));
      check("swap",       64'(dut_swap),       64'(m_swap_pulse));
      if (m_after_rst) begin
        check("rst_rd_data", 64'(dut_rd_data), 64'(0));
        check("rst_rd_idx",  64'(dut_rd_idx),  64'(0));
        check("rst_rd_last", 64'(dut_rd_last), 64'(0));
      end
      if (dut_rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_unexpected actual=idx%0d required=no_beat t=%0t", dut_rd_idx, $time);
        end else begin
          cur = exp_q[0];
          check("rd_idx",  64'(dut_rd_idx),  64'(cur[KW+AW-1:KW]));
          check("rd_data", 64'(dut_rd_data), 64'(cur[KW-1:0]));
          check("rd_last", 64'(dut_rd_last), 64'(cur[EW-1]));
          if (rd_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_keys(input logic [KW-1:0] base, input int n, input bit rnd);
    for (int k = 0; k < n; k++) begin
      logic        acc;
      int          waitc;
      logic [63:0] r;
      r        = {$urandom(), $urandom()};
      wr_valid = 1'b1;
      wr_data  = rnd ? r[KW-1:0] : base + KW'(k);
      waitc    = 0;
      acc      = 1'b0;
      while (!acc && waitc < 200) begin
        acc = dut_wr_ready;
        tick();
        waitc++;
      end
      check("wr_accept_timeout", 64'(acc), 64'(1));
    end
    wr_valid = 1'b0;
  endtask

  // mode 0: rd_ready held 1; mode 1: toggles 1,0,1,0; mode 2: random.
  // extra_at > 0 raises rd_start (with the opposite direction) mid-stream.
  task automatic run_stream(input logic dir, input int mode, input int extra_at);
    int cyc;
    cyc      = 0;
    rd_start = 1'b1;
    rd_dir   = dir;
    rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    while (m_stream && cyc < 200) begin
      cyc++;
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (cyc % 2 == 1);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      rd_start = (cyc == extra_at);
      rd_dir   = ~dir;
      tick();
    end
    rd_start = 1'b0;
    rd_ready = 1'b1;
    check("stream_timeout", 64'(m_stream), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    load_clear = 1'b0;
    rd_start   = 1'b0;
    rd_dir     = 1'b0;
    rd_ready   = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;

    // request before any complete set must be ignored
    run_stream(1'b0, 0, 0);
    repeat (2) tick();

    // basic load, encrypt stream, decrypt with backpressure, ignored mid-stream start
    write_keys(48'h000000000001, DEPTH, 1'b0);
    repeat (3) tick();
    run_stream(1'b0, 0, 0);
    tick();
    run_stream(1'b1, 1, 0);
    tick();
    run_stream(1'b0, 2, 3);
    tick();

    // second set loaded while the old one streams
    fork
      run_stream(1'b0, 2, 5);
      begin
        repeat (2) tick();
        write_keys(48'h000000000A00, DEPTH, 1'b0);
      end
    join
    repeat (3) tick();
    run_stream(1'b0, 0, 0);
    tick();

    // read request in the cycle the shadow bank becomes swap-eligible
    write_keys(48'h000000000B00, DEPTH, 1'b0);
    run_stream(1'b1, 0, 0);
    repeat (3) tick();
    run_stream(1'b1, 0, 0);
    tick();

    // load_clear with a write beat at wr_ptr = 7
    write_keys(48'h000000000C70, 7, 1'b0);
    wr_valid   = 1'b1;
    wr_data    = 48'h00000000DEAD;
    load_clear = 1'b1;
    tick();
    load_clear = 1'b0;
    wr_valid   = 1'b0;
    write_keys(48'h000000000C00, DEPTH, 1'b0);
    repeat (3) tick();
    run_stream(1'b0, 2, 0);
    tick();

    // reset at beat 5 of a stream
    rd_start = 1'b1;
    rd_dir   = 1'b0;
    rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_stream(1'b0, 0, 0);

    // reset at wr_ptr = 9 of a fill, then a fresh load works
    write_keys(48'h000000000E00, 9, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    write_keys(48'h000000000F00, DEPTH, 1'b0);
    repeat (3) tick();
    run_stream(1'b0, 0, 0);
    run_stream(1'b1, 2, 0);

    // randomized overlap of fills and streams
    for (int it = 0; it < 6; it++) begin
      fork
        run_stream(1'($urandom_range(0, 1)), 2, int'($urandom_range(0, 8)));
        begin
          repeat ($urandom_range(0, 20)) tick();
          write_keys('0, DEPTH, 1'b1);
        end
      join
      repeat ($urandom_range(0, 3)) tick();
    end
    repeat (3) tick();
    run_stream(1'($urandom_range(0, 1)), 2, 0);
    repeat (4) tick();

    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
